// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared widths, FSM state type and the RAM command payload for the two-master
// on-chip memory arbiter.
package onchip_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
        logic              write;
    } mem_cmd_t;

    // Bundle one requester's command fields into a RAM command
    function automatic mem_cmd_t make_cmd(
        input logic [ADDR_W-1:0] address,
        input logic [BE_W-1:0]   byteenable,
        input logic [DATA_W-1:0] writedata,
        input logic              write
    );
        mem_cmd_t cmd;
        cmd.address    = address;
        cmd.byteenable = byteenable;
        cmd.writedata  = writedata;
        cmd.write      = write;
        return cmd;
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered "last granted"
// pointer that moves only when a grant is issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt_c
);

    logic r_last;   // 1 when master 1 holds the most recent grant

    always_comb begin
        o_gnt_c = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt_c = 2'b01;
                2'b10:   o_gnt_c = 2'b10;
                2'b11:   o_gnt_c = r_last ? 2'b01 : 2'b10;
                default: o_gnt_c = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last <= 1'b0;
        end else if (o_gnt_c != 2'b00) begin
            r_last <= o_gnt_c[1];
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-style masters, optionally
// zero-filling the RAM after reset before arbitration starts.
module onchip_mem_arbiter
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter int unsigned DEPTH          = 8192
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy
);

    localparam state_t ST_INIT = (CLEAR_ON_RESET != 0) ? CLEAR : ARB;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt;
    logic              r_rd_pending, w_rd_pending_nxt;
    logic              r_rd_owner, w_rd_owner_nxt;
    logic [1:0]        w_req, w_gnt;
    logic              w_arb_en;
    mem_cmd_t          w_cmd;

    assign w_req    = {m1_read | m1_write, m0_read | m0_write};
    assign w_arb_en = reset_n && (r_state == ARB);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_arb_en),
        .i_req   (w_req),
        .o_gnt_c (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_INIT;
            r_clr_addr   <= '0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_addr   <= w_clr_addr_nxt;
            r_rd_pending <= w_rd_pending_nxt;
            r_rd_owner   <= w_rd_owner_nxt;
        end
    end

    // Outputs are held idle while reset is low so an in-flight read return is dropped
    always_comb begin
        w_state_nxt      = r_state;
        w_clr_addr_nxt   = r_clr_addr;
        w_rd_pending_nxt = 1'b0;
        w_rd_owner_nxt   = r_rd_owner;
        w_cmd            = '0;
        mem_chipselect   = 1'b0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        busy             = 1'b0;
        if (reset_n) begin
            case (r_state)
                CLEAR: begin
                    busy           = 1'b1;
                    mem_chipselect = 1'b1;
                    w_cmd          = make_cmd(r_clr_addr, '1, '0, 1'b1);
                    if (r_clr_addr == CLR_LAST) begin
                        w_state_nxt    = ARB;
                        w_clr_addr_nxt = '0;
                    end else begin
                        w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
                    end
                end
                ARB: begin
                    m0_readdatavalid = r_rd_pending && !r_rd_owner;
                    m1_readdatavalid = r_rd_pending &&  r_rd_owner;
                    m0_waitrequest   = !w_gnt[0];
                    m1_waitrequest   = !w_gnt[1];
                    if (w_gnt[0]) begin
                        mem_chipselect   = 1'b1;
                        w_cmd            = make_cmd(m0_address, m0_byteenable, m0_writedata, m0_write);
                        w_rd_pending_nxt = m0_read && !m0_write;
                        w_rd_owner_nxt   = 1'b0;
                    end else if (w_gnt[1]) begin
                        mem_chipselect   = 1'b1;
                        w_cmd            = make_cmd(m1_address, m1_byteenable, m1_writedata, m1_write);
                        w_rd_pending_nxt = m1_read && !m1_write;
                        w_rd_owner_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end
    end

    assign mem_address    = w_cmd.address;
    assign mem_byteenable = w_cmd.byteenable;
    assign mem_writedata  = w_cmd.writedata;
    assign mem_write      = w_cmd.write;
    assign mem_clken      = 1'b1;

    assign m0_readdata = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural single-port RAM
// (registered read, byte-lane writes) attached to the mem_* port.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_readdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // RAM model, preloaded with a non-zero pattern on its first edge
    logic [31:0] ram [0:8191];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 8192; i++) ram[i] <= 32'hA5A5_0000 | 32'(i);
            ram_loaded <= 1'b1;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    // Walk the clear sequence from address 'start' to the end, then expect ARB
    task automatic clear_run(input int start, input string tag);
        int bad;
        bad = 0;
        for (int k = start; k < 8192; k++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && mem_chipselect === 1'b1 && mem_write === 1'b1 &&
                  mem_address === 13'(k) && mem_writedata === 32'h0 && mem_byteenable === 4'hF &&
                  m0_waitrequest === 1'b1 && m1_waitrequest === 1'b1 &&
                  m0_readdatavalid === 1'b0 && m1_readdatavalid === 1'b0 && mem_clken === 1'b1))
                bad++;
        end
        check({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic ram_zero_check(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 8192; i++) if (ram[i] !== 32'h0) nz++;
        check({tag, "_nonzero_words"}, 32'(nz), 32'd0);
    endtask

    typedef struct {
        logic        m0_rd, m0_wr; logic [12:0] m0_a; logic [3:0] m0_be; logic [31:0] m0_wd;
        logic        m1_rd, m1_wr; logic [12:0] m1_a; logic [3:0] m1_be; logic [31:0] m1_wd;
        logic        e_w0, e_w1, e_cs, e_wr; logic [12:0] e_a; logic [3:0] e_be; logic [31:0] e_wd;
        logic        e_v0, e_v1; logic [31:0] e_d0, e_d1;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic g1, p1;
    int   rdv0_cnt, rdv1_cnt;

    initial begin
        // m0 stim | m1 stim | wait0 wait1 cs wr addr be wdata | rdv0 rdv1 data0 data1
        vecs[0]  = '{0,0,13'h000,4'h0,32'h0,        0,0,13'h000,4'h0,32'h0,   1,1,0,0,13'h000,4'h0,32'h0,        0,0,32'h0,32'h0};
        vecs[1]  = '{0,1,13'h030,4'hC,32'hAABBCCDD, 0,0,13'h000,4'h0,32'h0,   0,1,1,1,13'h030,4'hC,32'hAABBCCDD, 0,0,32'h0,32'h0};
        vecs[2]  = '{1,0,13'h030,4'hF,32'h0,        1,0,13'h020,4'hF,32'h0,   1,0,1,0,13'h020,4'h0,32'h0,        0,0,32'h0,32'h0};
        vecs[3]  = '{1,0,13'h030,4'hF,32'h0,        0,0,13'h000,4'h0,32'h0,   0,1,1,0,13'h030,4'h0,32'h0,        0,1,32'h0,32'h12345678};
        vecs[4]  = '{1,1,13'h040,4'hF,32'h11112222, 0,0,13'h000,4'h0,32'h0,   0,1,1,1,13'h040,4'hF,32'h11112222, 1,0,32'hAABB0000,32'h0};
        vecs[5]  = '{0,0,13'h000,4'h0,32'h0,        1,0,13'h040,4'hF,32'h0,   1,0,1,0,13'h040,4'h0,32'h0,        0,0,32'h0,32'h0};
        vecs[6]  = '{1,0,13'h010,4'hF,32'h0,        1,0,13'h100,4'hF,32'h0,   0,1,1,0,13'h010,4'h0,32'h0,        0,1,32'h0,32'h11112222};
        vecs[7]  = '{0,0,13'h000,4'h0,32'h0,        1,0,13'h100,4'hF,32'h0,   1,0,1,0,13'h100,4'h0,32'h0,        1,0,32'h0000BEEF,32'h0};
        vecs[8]  = '{0,0,13'h000,4'h0,32'h0,        0,0,13'h000,4'h0,32'h0,   1,1,0,0,13'h000,4'h0,32'h0,        0,1,32'h0,32'hCAFEF00D};
        vecs[9]  = '{0,1,13'h000,4'hF,32'h00000055, 0,1,13'h1FFF,4'h1,32'hEE, 0,1,1,1,13'h000,4'hF,32'h00000055, 0,0,32'h0,32'h0};
        vecs[10] = '{0,0,13'h000,4'h0,32'h0,        0,1,13'h1FFF,4'h1,32'hEE, 1,0,1,1,13'h1FFF,4'h1,32'h000000EE,0,0,32'h0,32'h0};
        vecs[11] = '{1,0,13'h1FFF,4'hF,32'h0,       1,0,13'h000,4'hF,32'h0,   0,1,1,0,13'h1FFF,4'h0,32'h0,       0,0,32'h0,32'h0};
        vecs[12] = '{0,0,13'h000,4'h0,32'h0,        1,0,13'h000,4'hF,32'h0,   1,0,1,0,13'h000,4'h0,32'h0,        1,0,32'h000000EE,32'h0};
        vecs[13] = '{0,0,13'h000,4'h0,32'h0,        0,0,13'h000,4'h0,32'h0,   1,1,0,0,13'h000,4'h0,32'h0,        0,1,32'h0,32'h00000055};

        reset_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_wait0", 32'(m0_waitrequest), 1);
        check("rst_wait1", 32'(m1_waitrequest), 1);
        check("rst_cs", 32'(mem_chipselect), 0);
        check("rst_wr", 32'(mem_write), 0);
        check("rst_rdv0", 32'(m0_readdatavalid), 0);
        check("rst_rdv1", 32'(m1_readdatavalid), 0);
        next_cycle();
        reset_n = 1'b1;

        clear_run(0, "clear1");
        ram_zero_check("clear1");
        next_cycle();

        // Read of the last word after clearing returns zero
        m0_address = 13'h1FFF; m0_read = 1'b1;
        @(negedge clk);
        check("last_wait0", 32'(m0_waitrequest), 0);
        check("last_cs", 32'(mem_chipselect), 1);
        check("last_addr", 32'(mem_address), 32'h1FFF);
        next_cycle();
        m0_read = 1'b0;
        @(negedge clk);
        check("last_rdv0", 32'(m0_readdatavalid), 1);
        check("last_rdv1", 32'(m1_readdatavalid), 0);
        check("last_data", m0_readdata, 32'h0);
        next_cycle();

        // m1 seeds 0x20 (moves pointer to m1)
        m1_address = 13'h020; m1_byteenable = 4'hF; m1_writedata = 32'h12345678; m1_write = 1'b1;
        @(negedge clk);
        check("seed_wait1", 32'(m1_waitrequest), 0);
        check("seed_wait0_idle", 32'(m0_waitrequest), 1);
        check("seed_wr", 32'(mem_write), 1);
        check("seed_addr", 32'(mem_address), 32'h020);
        next_cycle();
        m1_write = 1'b0;

        // Partial-lane write then read-back
        m0_address = 13'h010; m0_byteenable = 4'h3; m0_writedata = 32'hDEADBEEF; m0_write = 1'b1;
        @(negedge clk);
        check("be_wait0", 32'(m0_waitrequest), 0);
        check("be_wr", 32'(mem_write), 1);
        check("be_be", 32'(mem_byteenable), 32'h3);
        check("be_wdata", mem_writedata, 32'hDEADBEEF);
        next_cycle();
        m0_write = 1'b0; m0_read = 1'b1;
        @(negedge clk);
        check("be_rd_wait0", 32'(m0_waitrequest), 0);
        check("be_rd_wr", 32'(mem_write), 0);
        check("be_rd_rdv_early", 32'(m0_readdatavalid), 0);
        next_cycle();
        m0_read = 1'b0;
        @(negedge clk);
        check("be_rd_rdv", 32'(m0_readdatavalid), 1);
        check("be_rd_data", m0_readdata, 32'h0000BEEF);
        next_cycle();

        // Both masters read continuously: m1, m0, m1, ... with no bubbles
        m0_address = 13'h010; m0_read = 1'b1;
        m1_address = 13'h020; m1_read = 1'b1;
        rdv0_cnt = 0; rdv1_cnt = 0; p1 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            g1 = (j % 2 == 0);
            @(negedge clk);
            check($sformatf("rr%0d_wait1", j), 32'(m1_waitrequest), 32'(!g1));
            check($sformatf("rr%0d_wait0", j), 32'(m0_waitrequest), 32'(g1));
            check($sformatf("rr%0d_addr", j), 32'(mem_address), g1 ? 32'h020 : 32'h010);
            if (j > 0) begin
                check($sformatf("rr%0d_rdv1", j), 32'(m1_readdatavalid), 32'(p1));
                check($sformatf("rr%0d_rdv0", j), 32'(m0_readdatavalid), 32'(!p1));
                check($sformatf("rr%0d_data", j), p1 ? m1_readdata : m0_readdata,
                      p1 ? 32'h12345678 : 32'h0000BEEF);
            end
            rdv0_cnt += int'(m0_readdatavalid);
            rdv1_cnt += int'(m1_readdatavalid);
            p1 = g1;
            next_cycle();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        @(negedge clk);
        check("rr_tail_rdv0", 32'(m0_readdatavalid), 1);
        check("rr_tail_rdv1", 32'(m1_readdatavalid), 0);
        check("rr_tail_data", m0_readdata, 32'h0000BEEF);
        rdv0_cnt += int'(m0_readdatavalid);
        rdv1_cnt += int'(m1_readdatavalid);
        check("rr_rdv0_count", 32'(rdv0_cnt), 3);
        check("rr_rdv1_count", 32'(rdv1_cnt), 3);
        next_cycle();

        // Same-cycle m1 write / m0 read of 0x100: write first, read sees new data
        m1_address = 13'h100; m1_byteenable = 4'hF; m1_writedata = 32'hCAFEF00D; m1_write = 1'b1;
        m0_address = 13'h100; m0_read = 1'b1;
        @(negedge clk);
        check("wr_rd_wait1", 32'(m1_waitrequest), 0);
        check("wr_rd_wait0", 32'(m0_waitrequest), 1);
        check("wr_rd_wr", 32'(mem_write), 1);
        next_cycle();
        m1_write = 1'b0;
        @(negedge clk);
        check("wr_rd_wait0_b", 32'(m0_waitrequest), 0);
        check("wr_rd_addr", 32'(mem_address), 32'h100);
        next_cycle();
        m0_read = 1'b0;
        @(negedge clk);
        check("wr_rd_rdv0", 32'(m0_readdatavalid), 1);
        check("wr_rd_data", m0_readdata, 32'hCAFEF00D);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            m0_read = vecs[i].m0_rd; m0_write = vecs[i].m0_wr; m0_address = vecs[i].m0_a;
            m0_byteenable = vecs[i].m0_be; m0_writedata = vecs[i].m0_wd;
            m1_read = vecs[i].m1_rd; m1_write = vecs[i].m1_wr; m1_address = vecs[i].m1_a;
            m1_byteenable = vecs[i].m1_be; m1_writedata = vecs[i].m1_wd;
            @(negedge clk);
            check($sformatf("v%0d_wait0", i), 32'(m0_waitrequest), 32'(vecs[i].e_w0));
            check($sformatf("v%0d_wait1", i), 32'(m1_waitrequest), 32'(vecs[i].e_w1));
            check($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(vecs[i].e_cs));
            check($sformatf("v%0d_wr", i), 32'(mem_write), 32'(vecs[i].e_wr));
            if (vecs[i].e_cs) check($sformatf("v%0d_addr", i), 32'(mem_address), 32'(vecs[i].e_a));
            if (vecs[i].e_wr) begin
                check($sformatf("v%0d_be", i), 32'(mem_byteenable), 32'(vecs[i].e_be));
                check($sformatf("v%0d_wdata", i), mem_writedata, vecs[i].e_wd);
            end
            check($sformatf("v%0d_rdv0", i), 32'(m0_readdatavalid), 32'(vecs[i].e_v0));
            check($sformatf("v%0d_rdv1", i), 32'(m1_readdatavalid), 32'(vecs[i].e_v1));
            check($sformatf("v%0d_data0", i), m0_readdata, vecs[i].e_d0);
            check($sformatf("v%0d_data1", i), m1_readdata, vecs[i].e_d1);
            next_cycle();
        end
        drive_idle();

        // Reset the cycle after a read grant: the return must never appear
        m0_address = 13'h010; m0_read = 1'b1;
        @(negedge clk);
        check("abort_wait0", 32'(m0_waitrequest), 0);
        next_cycle();
        reset_n = 1'b0; m0_read = 1'b0;
        @(negedge clk);
        check("abort_rdv0", 32'(m0_readdatavalid), 0);
        check("abort_rdv1", 32'(m1_readdatavalid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_cs", 32'(mem_chipselect), 0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_rdv0_after", 32'(m0_readdatavalid), 0);
        check("abort_busy_after", 32'(busy), 1);
        check("abort_clr_addr0", 32'(mem_address), 0);

        // Reset at clear address 100 restarts the fill from 0
        repeat (100) @(negedge clk);
        check("mid_clr_addr100", 32'(mem_address), 100);
        check("mid_clr_busy", 32'(busy), 1);
        next_cycle();
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_clr_rst_busy", 32'(busy), 0);
        check("mid_clr_rst_cs", 32'(mem_chipselect), 0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("restart_busy", 32'(busy), 1);
        check("restart_addr", 32'(mem_address), 0);
        check("restart_wr", 32'(mem_write), 1);
        clear_run(1, "clear2");
        ram_zero_check("clear2");
        next_cycle();

        m1_address = 13'h020; m1_read = 1'b1;
        @(negedge clk);
        check("post_wait1", 32'(m1_waitrequest), 0);
        next_cycle();
        m1_read = 1'b0;
        @(negedge clk);
        check("post_rdv1", 32'(m1_readdatavalid), 1);
        check("post_data1", m1_readdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
